// File: rtl/calendar_pkg.sv
// Shared constants for the calendar controller: state encoding, BCD limits
// and the non-leap days-per-month table with its lookup helpers.
package calendar_pkg;

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_SET_MONTH = 2'd1;
  localparam logic [1:0] ST_SET_DAY   = 2'd2;

  localparam logic [7:0] BCD_01 = 8'h01;
  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_31 = 8'h31;

  // Entry 0 is January; every entry is already in BCD.
  localparam logic [0:11][7:0] DAYS_TABLE = {
    8'h31, 8'h28, 8'h31, 8'h30, 8'h31, 8'h30,
    8'h31, 8'h31, 8'h30, 8'h31, 8'h30, 8'h31
  };

  function automatic logic [7:0] days_in_month(input logic [7:0] month);
    logic [7:0] bin;
    logic [3:0] idx;
    bin = {4'd0, month[3:0]} + ((month[7:4] == 4'd1) ? 8'd10 : 8'd0);
    idx = 4'(bin - 8'd1);
    days_in_month = BCD_31;
    if (bin >= 8'd1 && bin <= 8'd12) days_in_month = DAYS_TABLE[idx];
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] value);
    if (value[3:0] == 4'd9) bcd_inc = {value[7:4] + 4'd1, 4'd0};
    else                    bcd_inc = {value[7:4], value[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/calendar_ctrl_bcd2_counter.sv
// Two-digit BCD register that wraps to 01 after a run-time maximum;
// a load takes priority over an increment.
module bcd2_counter
  import calendar_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic [7:0] max,
  output logic [7:0] value
);

  // Packed BCD orders the same as binary, so >= also catches stale values above max.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= BCD_01;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      value <= (value >= max) ? BCD_01 : bcd_inc(value);
    end
  end

endmodule

// File: rtl/calendar_ctrl.sv
// Day/month calendar with a three-state set FSM, day clamping when leaving
// month setting, and a blink divider that blanks the field being edited.
module calendar_ctrl
  import calendar_pkg::*;
#(
  parameter int BLINK_DIV          = 5_000_000,
  parameter int TICK_ENABLE_IN_SET = 0
) (
  input  logic       ADC_CLK_10,
  input  logic       reset,
  input  logic       tick,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [7:0] day_bcd,
  output logic [7:0] month_bcd,
  output logic [1:0] mode,
  output logic       blank_day,
  output logic       blank_month
);

  localparam int             CW          = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0]  BLINK_LAST  = CW'(BLINK_DIV - 1);
  localparam logic           TICK_IN_SET = (TICK_ENABLE_IN_SET != 0);

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [CW-1:0] blink_cnt;
  logic          blink_phase;

  logic          mode_go;
  logic          inc_go;
  logic          tick_go;
  logic          day_inc;
  logic          month_inc;
  logic          day_load;
  logic          entering_set;
  logic [7:0]    day_max;

  // key_mode > key_inc > tick: the winner alone acts, even if it is a no-op
  // (key_inc in RUN still swallows a coincident tick).
  always_comb begin
    mode_go      = key_mode;
    inc_go       = key_inc & ~key_mode;
    tick_go      = tick & ~key_mode & ~key_inc & ((state == ST_RUN) | TICK_IN_SET);

    case (state)
      ST_RUN:       state_next = ST_SET_MONTH;
      ST_SET_MONTH: state_next = ST_SET_DAY;
      default:      state_next = ST_RUN;
    endcase

    day_max      = days_in_month(month_bcd);
    day_inc      = tick_go | (inc_go & (state == ST_SET_DAY));
    month_inc    = (tick_go & (day_bcd >= day_max)) | (inc_go & (state == ST_SET_MONTH));
    day_load     = mode_go & (state == ST_SET_MONTH) & (day_bcd > day_max);
    entering_set = mode_go & (state_next != ST_RUN);
  end

  always_ff @(posedge ADC_CLK_10) begin
    if (reset) begin
      state <= ST_RUN;
    end else if (mode_go) begin
      state <= state_next;
    end
  end

  // Restarting the divider on entry keeps the newly selected field visible first.
  always_ff @(posedge ADC_CLK_10) begin
    if (reset || entering_set) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + CW'(1);
    end
  end

  bcd2_counter u_day (
    .clk      (ADC_CLK_10),
    .reset    (reset),
    .inc      (day_inc),
    .load     (day_load),
    .load_val (day_max),
    .max      (day_max),
    .value    (day_bcd)
  );

  bcd2_counter u_month (
    .clk      (ADC_CLK_10),
    .reset    (reset),
    .inc      (month_inc),
    .load     (1'b0),
    .load_val (BCD_01),
    .max      (BCD_12),
    .value    (month_bcd)
  );

  assign mode        = state;
  assign blank_month = blink_phase & (state == ST_SET_MONTH);
  assign blank_day   = blink_phase & (state == ST_SET_DAY);

endmodule

// File: tb/tb_calendar_ctrl.sv
// Bench for calendar_ctrl: directed scenarios plus random strobes checked
// against an integer day/month reference model.
module tb_calendar_ctrl;

  localparam int BLINK = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       key_mode = 1'b0;
  logic       key_inc = 1'b0;
  logic [7:0] day_bcd;
  logic [7:0] month_bcd;
  logic [1:0] mode;
  logic       blank_day;
  logic       blank_month;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integers, mode number, cycles since last key_mode.
  int m_day, m_month, m_mode, m_since;
  int dim_tab[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  calendar_ctrl #(.BLINK_DIV(BLINK), .TICK_ENABLE_IN_SET(0)) dut (
    .ADC_CLK_10  (clk),
    .reset       (reset),
    .tick        (tick),
    .key_mode    (key_mode),
    .key_inc     (key_inc),
    .day_bcd     (day_bcd),
    .month_bcd   (month_bcd),
    .mode        (mode),
    .blank_day   (blank_day),
    .blank_month (blank_month)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] b;
    b[7:4] = 4'(v / 10);
    b[3:0] = 4'(v % 10);
    return b;
  endfunction

  function automatic int dim(input int mo);
    return dim_tab[mo - 1];
  endfunction

  function automatic logic exp_blank(input int which_mode);
    return (m_mode == which_mode) && (((m_since / BLINK) % 2) == 1);
  endfunction

  function automatic void model_step(input logic r, input logic km, input logic ki, input logic tk);
    if (r) begin
      m_day = 1; m_month = 1; m_mode = 0; m_since = 0;
    end else if (km) begin
      if (m_mode == 1 && m_day > dim(m_month)) m_day = dim(m_month);
      m_mode  = (m_mode + 1) % 3;
      m_since = 0;
    end else begin
      m_since++;
      if (ki) begin
        if (m_mode == 1) m_month = (m_month % 12) + 1;
        else if (m_mode == 2) m_day = (m_day >= dim(m_month)) ? 1 : m_day + 1;
      end else if (tk && m_mode == 0) begin
        if (m_day < dim(m_month)) m_day++;
        else begin
          m_day = 1;
          m_month = (m_month % 12) + 1;
        end
      end
    end
  endfunction

  task automatic drive(input logic r, input logic km, input logic ki, input logic tk);
    @(negedge clk);
    reset = r; key_mode = km; key_inc = ki; tick = tk;
    @(posedge clk);
    model_step(r, km, ki, tk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0);
    drive(1, 1, 1, 1);
    checks++;
    if (day_bcd !== 8'h01) begin errors++; $display("FAIL reset_day: got %h want 01", day_bcd); end
    checks++;
    if (month_bcd !== 8'h01) begin errors++; $display("FAIL reset_month: got %h want 01", month_bcd); end
    checks++;
    if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d want 0", mode); end
    checks++;
    if ({blank_day, blank_month} !== 2'b00) begin
      errors++; $display("FAIL reset_blank: got %b want 00", {blank_day, blank_month});
    end
  endtask

  task automatic test_run_ticks();
    for (int i = 1; i <= 30; i++) begin
      drive(0, 0, 0, 1);
      checks++;
      if (day_bcd !== to_bcd(i + 1) || day_bcd !== to_bcd(m_day)) begin
        errors++; $display("FAIL tick_day_%0d: got %h want %h", i, day_bcd, to_bcd(i + 1));
      end
    end
    drive(0, 0, 0, 1);
    checks++;
    if ({month_bcd, day_bcd} !== 16'h0201) begin
      errors++; $display("FAIL jan_rollover: got %h/%h want 02/01", month_bcd, day_bcd);
    end
    for (int i = 0; i < 28; i++) drive(0, 0, 0, 1);
    checks++;
    if ({month_bcd, day_bcd} !== 16'h0301) begin
      errors++; $display("FAIL feb_rollover: got %h/%h want 03/01", month_bcd, day_bcd);
    end
  endtask

  task automatic test_year_wrap();
    drive(0, 1, 0, 0);
    while (m_month != 12) drive(0, 0, 1, 0);
    drive(0, 1, 0, 0);
    while (m_day != 31) drive(0, 0, 1, 0);
    drive(0, 1, 0, 0);
    checks++;
    if ({mode, month_bcd, day_bcd} !== {2'd0, 16'h1231}) begin
      errors++; $display("FAIL preload_1231: got %0d %h/%h want 0 12/31", mode, month_bcd, day_bcd);
    end
    drive(0, 0, 0, 1);
    checks++;
    if ({month_bcd, day_bcd} !== 16'h0101) begin
      errors++; $display("FAIL year_wrap: got %h/%h want 01/01", month_bcd, day_bcd);
    end
  endtask

  task automatic test_clamp();
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    while (m_day != 31) drive(0, 0, 1, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 0, 1, 0);
    checks++;
    if ({mode, month_bcd, day_bcd} !== {2'd1, 16'h0231}) begin
      errors++; $display("FAIL pre_clamp: got %0d %h/%h want 1 02/31", mode, month_bcd, day_bcd);
    end
    drive(0, 1, 0, 0);
    checks++;
    if ({mode, day_bcd} !== {2'd2, 8'h28}) begin
      errors++; $display("FAIL clamp_28: got mode %0d day %h want 2 28", mode, day_bcd);
    end
  endtask

  task automatic test_priority();
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 1);
    checks++;
    if ({mode, month_bcd, day_bcd} !== {2'd1, 16'h0228}) begin
      errors++; $display("FAIL mode_beats_tick: got %0d %h/%h want 1 02/28", mode, month_bcd, day_bcd);
    end
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 1);
    checks++;
    if ({mode, month_bcd, day_bcd} !== {2'd2, 16'h0228}) begin
      errors++; $display("FAIL tick_dropped_set: got %0d %h/%h want 2 02/28", mode, month_bcd, day_bcd);
    end
    drive(0, 0, 1, 1);
    checks++;
    if ({month_bcd, day_bcd} !== 16'h0201) begin
      errors++; $display("FAIL inc_beats_tick: got %h/%h want 02/01", month_bcd, day_bcd);
    end
  endtask

  task automatic test_blink();
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    checks++;
    if (blank_month !== 1'b0) begin errors++; $display("FAIL blink_entry_month: got %b want 0", blank_month); end
    for (int k = 1; k <= 12; k++) begin
      drive(0, 0, 0, 0);
      checks++;
      if (blank_month !== (((k / 4) % 2) == 1) || blank_month !== exp_blank(1) || blank_day !== 1'b0) begin
        errors++; $display("FAIL blink_month_%0d: got m%b d%b want m%b d0", k, blank_month, blank_day, exp_blank(1));
      end
    end
    drive(0, 1, 0, 0);
    checks++;
    if ({blank_day, blank_month} !== 2'b00) begin
      errors++; $display("FAIL blink_entry_day: got %b want 00", {blank_day, blank_month});
    end
    for (int k = 0; k < 4; k++) drive(0, 0, 0, 0);
    checks++;
    if ({blank_day, blank_month} !== 2'b10) begin
      errors++; $display("FAIL blink_day_on: got %b want 10", {blank_day, blank_month});
    end
  endtask

  task automatic test_reset_mid_set();
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(1, 0, 1, 0);
    checks++;
    if ({mode, month_bcd, day_bcd, blank_day, blank_month} !== {2'd0, 16'h0101, 2'b00}) begin
      errors++; $display("FAIL reset_mid_set: got %0d %h/%h b%b%b want 0 01/01 b00",
                         mode, month_bcd, day_bcd, blank_day, blank_month);
    end
    drive(0, 0, 0, 1);
    checks++;
    if (day_bcd !== 8'h02) begin errors++; $display("FAIL first_strobe: got %h want 02", day_bcd); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
      checks++;
      if (day_bcd !== to_bcd(m_day) || month_bcd !== to_bcd(m_month) || mode !== 2'(m_mode) ||
          blank_month !== exp_blank(1) || blank_day !== exp_blank(2)) begin
        errors++;
        $display("FAIL random_%0d: got %0d %h/%h b%b%b want %0d %h/%h b%b%b", n,
                 mode, month_bcd, day_bcd, blank_day, blank_month,
                 m_mode, to_bcd(m_month), to_bcd(m_day), exp_blank(2), exp_blank(1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_ticks();
    test_year_wrap();
    test_clamp();
    test_priority();
    test_blink();
    test_reset_mid_set();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
